// File: rtl/br_flow_demux_select_buffered_if.sv
// Push/pop bundle for br_flow_demux_select_buffered.
// slave: the demux itself. master: the producer/consumer side.
interface br_flow_demux_select_buffered_if #(
    parameter int NumRequesters = 2,
    parameter int BitWidth      = 1,
    parameter int CountWidth    = 16
);
    localparam int SelWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

    logic [SelWidth-1:0]                      push_select;
    logic                                     push_ready;
    logic                                     push_valid;
    logic [BitWidth-1:0]                      push_data;
    logic [NumRequesters-1:0]                 pop_ready;
    logic [NumRequesters-1:0]                 pop_valid;
    logic [NumRequesters-1:0][BitWidth-1:0]   pop_data;
    logic [NumRequesters-1:0][CountWidth-1:0] pop_count;

    modport master (
        output push_select, push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, pop_count
    );

    modport slave (
        input  push_select, push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, pop_count
    );
endinterface

// File: rtl/br_flow_demux_select_buffered.sv
// Buffered select demux: one producer steered by push_select into one of
// NumRequesters independent flop FIFOs, each feeding its own consumer.
// Optional macro BR_FLOW_DEMUX_SELECT_BUFFERED_COUNT_EN adds a saturating
// per-requester pop counter on pop_count; without it pop_count is tied to 0.
// BR_ASSERT_INTG enables checks on the producer's handshake behaviour.

// One requester lane: a Depth-entry circular FIFO with registered outputs.
module br_flow_demux_select_buffered_fifo #(
    parameter int BitWidth   = 1,
    parameter int Depth      = 2,
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [BitWidth-1:0]   push_data_i,
    input  logic                  pop_ready_i,
    output logic                  full_o,
    output logic                  pop_valid_o,
    output logic [BitWidth-1:0]   pop_data_o,
    output logic [CountWidth-1:0] pop_count_o
);
    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int OccWidth = $clog2(Depth + 1);

    logic [Depth-1:0][BitWidth-1:0] mem_q, mem_d;
    logic [PtrWidth-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]            rd_ptr_q, rd_ptr_d;
    logic [OccWidth-1:0]            occ_q, occ_d;
    logic                           pop;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // All outputs come straight from flops: no path from push to pop side.
    assign full_o      = (occ_q == OccWidth'(Depth));
    assign pop_valid_o = (occ_q != '0);
    assign pop_data_o  = mem_q[rd_ptr_q];
    assign pop         = pop_valid_o & pop_ready_i;

    // Next-state: write at tail, advance head on pop, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop})
            2'b10:   occ_d = occ_q + OccWidth'(1);
            2'b01:   occ_d = occ_q - OccWidth'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage and pointers; reset empties the lane and zeroes the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

`ifdef BR_FLOW_DEMUX_SELECT_BUFFERED_COUNT_EN
    logic [CountWidth-1:0] count_q, count_d;

    // Count pops, holding at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (pop && (count_q != '1)) begin
            count_d = count_q + CountWidth'(1);
        end
    end

    // Counter register; value appears the cycle after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pop_count_o = count_q;
`else
    assign pop_count_o = '0;
`endif

    // Offered entry stays put until the consumer takes it.
    a_pop_stable: assert property (@(posedge clk) disable iff (rst)
        pop_valid_o && !pop_ready_i |=> pop_valid_o && $stable(pop_data_o));
    a_occ_bound: assert property (@(posedge clk) disable iff (rst)
        occ_q <= OccWidth'(Depth));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_o));
endmodule

module br_flow_demux_select_buffered #(
    parameter int NumRequesters = 2,
    parameter int BitWidth      = 1,
    parameter int Depth         = 2,
    parameter int CountWidth    = 16
) (
    input logic                           clk,
    input logic                           rst,
    br_flow_demux_select_buffered_if.slave bus
);
    localparam int SelWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

    if (NumRequesters < 2) begin : g_chk_nreq
        $error("NumRequesters must be >= 2");
    end
    if (BitWidth < 1) begin : g_chk_width
        $error("BitWidth must be >= 1");
    end
    if (Depth < 1) begin : g_chk_depth
        $error("Depth must be >= 1");
    end
    if (CountWidth < 1) begin : g_chk_cwidth
        $error("CountWidth must be >= 1");
    end

    logic [NumRequesters-1:0]                 full;
    logic [NumRequesters-1:0]                 push_hit;
    logic [NumRequesters-1:0]                 pop_valid;
    logic [NumRequesters-1:0][BitWidth-1:0]   pop_data;
    logic [NumRequesters-1:0][CountWidth-1:0] pop_count;
    logic                                     push_ready;

    // Ready looks only at the selected lane's registered fullness, so a
    // full lane never accepts even if it is popping this same cycle.
    always_comb begin
        push_ready = 1'b0;
        for (int i = 0; i < NumRequesters; i++) begin
            if (bus.push_select == SelWidth'(i)) begin
                push_ready = !full[i];
            end
        end
        if (rst) begin
            push_ready = 1'b0;
        end
    end

    for (genvar i = 0; i < NumRequesters; i++) begin : g_lane
        assign push_hit[i] = bus.push_valid & push_ready &
                             (bus.push_select == SelWidth'(i));

        br_flow_demux_select_buffered_fifo #(
            .BitWidth  (BitWidth),
            .Depth     (Depth),
            .CountWidth(CountWidth)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_i     (push_hit[i]),
            .push_data_i(bus.push_data),
            .pop_ready_i(bus.pop_ready[i]),
            .full_o     (full[i]),
            .pop_valid_o(pop_valid[i]),
            .pop_data_o (pop_data[i]),
            .pop_count_o(pop_count[i])
        );
    end

    assign bus.push_ready = push_ready;
    assign bus.pop_valid  = pop_valid;
    assign bus.pop_data   = pop_data;
    assign bus.pop_count  = pop_count;

`ifdef BR_ASSERT_INTG
    a_sel_range: assert property (@(posedge clk) disable iff (rst)
        bus.push_valid |-> int'(bus.push_select) < NumRequesters);
    a_push_hold: assert property (@(posedge clk) disable iff (rst)
        bus.push_valid && !push_ready |=>
        bus.push_valid && $stable(bus.push_data) && $stable(bus.push_select));
`endif
endmodule

// File: tb/tb_br_flow_demux_select_buffered.sv
// Directed bench for br_flow_demux_select_buffered (4 requesters, 8-bit,
// Depth 2, CountWidth 2). Stimulus pushes hand-chosen payloads into
// per-requester expectation queues; a negedge monitor pops and compares on
// every pop transfer.
module tb_br_flow_demux_select_buffered;
    localparam int NR    = 4;
    localparam int BW    = 8;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    br_flow_demux_select_buffered_if #(
        .NumRequesters(NR), .BitWidth(BW), .CountWidth(CW)
    ) bus ();

    br_flow_demux_select_buffered #(
        .NumRequesters(NR), .BitWidth(BW), .Depth(DEPTH), .CountWidth(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] exp_q [NR][$];
    logic [BW-1:0] mon_exp;

`ifdef BR_FLOW_DEMUX_SELECT_BUFFERED_COUNT_EN
    int cnt_exp [5] = '{1, 2, 3, 3, 3};
`else
    int cnt_exp [5] = '{0, 0, 0, 0, 0};
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push(input int sel, input logic [BW-1:0] d, input logic exp_rdy);
        bus.push_valid  = 1'b1;
        bus.push_select = 2'(sel);
        bus.push_data   = d;
        neg();
        chk($sformatf("push_ready_sel%0d", sel), 32'(bus.push_ready), 32'(exp_rdy));
        if (exp_rdy) exp_q[sel].push_back(d);
        cyc();
    endtask

    // Scoreboard monitor: every pop transfer must match the queue head.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            for (int i = 0; i < NR; i++) begin
                if (bus.pop_valid[i] && bus.pop_ready[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL pop%0d_unexpected: got 0x%0h expected no entry", i, bus.pop_data[i]);
                    end else begin
                        mon_exp = exp_q[i].pop_front();
                        if (bus.pop_data[i] !== mon_exp) begin
                            errors++;
                            $display("FAIL pop%0d_data: got 0x%0h expected 0x%0h", i, bus.pop_data[i], mon_exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.push_valid  = 1'b0;
        bus.push_select = '0;
        bus.push_data   = '0;
        bus.pop_ready   = '0;

        // Reset state
        cyc(); cyc();
        neg();
        chk("rst_pop_valid", 32'(bus.pop_valid), 0);
        chk("rst_pop_count", 32'(bus.pop_count), 0);
        chk("rst_push_ready", 32'(bus.push_ready), 0);
        cyc();
        rst = 1'b0;

        // Single push to requester 1, no bypass
        bus.push_valid  = 1'b1;
        bus.push_select = 2'd1;
        bus.push_data   = 8'hA5;
        neg();
        chk("t1_push_ready", 32'(bus.push_ready), 1);
        chk("t1_no_bypass", 32'(bus.pop_valid), 0);
        exp_q[1].push_back(8'hA5);
        cyc();
        bus.push_valid = 1'b0;
        neg();
        chk("t1_pop_valid", 32'(bus.pop_valid), 32'h2);
        chk("t1_pop_data1", 32'(bus.pop_data[1]), 32'hA5);
        cyc();
        bus.pop_ready = 4'b0010;
        cyc();
        bus.pop_ready = 4'b0000;
        neg();
        chk("t1_drained", 32'(bus.pop_valid), 0);
        cyc();

        // Requester 2 full blocks only its own select
        push(2, 8'h11, 1'b1);
        push(2, 8'h22, 1'b1);
        bus.push_valid  = 1'b0;
        bus.push_select = 2'd2;
        neg();
        chk("t2_full_ready", 32'(bus.push_ready), 0);
        cyc();
        push(0, 8'h33, 1'b1);

        // Full lane popping in same cycle: still not ready
        bus.push_valid  = 1'b1;
        bus.push_select = 2'd2;
        bus.push_data   = 8'h44;
        bus.pop_ready   = 4'b0100;
        neg();
        chk("t3_no_passthru", 32'(bus.push_ready), 0);
        cyc();
        bus.pop_ready = 4'b0000;
        neg();
        chk("t3_ready_after_pop", 32'(bus.push_ready), 1);
        exp_q[2].push_back(8'h44);
        cyc();
        bus.push_valid = 1'b0;
        bus.pop_ready  = 4'b0101;
        neg();
        chk("t3_next_head", 32'(bus.pop_data[2]), 32'h22);
        cyc();
        cyc();
        bus.pop_ready = 4'b0000;
        neg();
        chk("t3_drained", 32'(bus.pop_valid), 0);
        cyc();

        // Streaming through requester 3 with pointer wrap
        bus.pop_ready = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            bus.push_valid  = 1'b1;
            bus.push_select = 2'd3;
            bus.push_data   = 8'(k);
            neg();
            chk($sformatf("t4_ready_%0d", k), 32'(bus.push_ready), 1);
            if (k > 0) begin
                chk($sformatf("t4_valid_%0d", k), 32'(bus.pop_valid), 32'h8);
                chk($sformatf("t4_head_%0d", k), 32'(bus.pop_data[3]), 32'(k - 1));
            end
            exp_q[3].push_back(8'(k));
            cyc();
        end
        bus.push_valid = 1'b0;
        neg();
        chk("t4_last_valid", 32'(bus.pop_valid), 32'h8);
        cyc();
        bus.pop_ready = 4'b0000;
        neg();
        chk("t4_drained", 32'(bus.pop_valid), 0);
        cyc();

        // Mid-operation reset discards buffered entries
        push(0, 8'h60, 1'b1);
        push(0, 8'h61, 1'b1);
        push(1, 8'h62, 1'b1);
        push(1, 8'h63, 1'b1);
        bus.push_valid = 1'b0;
        neg();
        chk("t5_filled", 32'(bus.pop_valid), 32'h3);
        cyc();
        rst = 1'b1;
        neg();
        chk("t5_ready_in_rst", 32'(bus.push_ready), 0);
        for (int i = 0; i < NR; i++) exp_q[i].delete();
        cyc();
        rst = 1'b0;
        neg();
        chk("t5_valid_after_rst", 32'(bus.pop_valid), 0);
        for (int s = 0; s < NR; s++) begin
            bus.push_select = 2'(s);
            #1;
            chk($sformatf("t5_ready_sel%0d", s), 32'(bus.push_ready), 1);
        end
        cyc();
        bus.pop_ready = 4'b1111;
        cyc();
        cyc();
        neg();
        chk("t5_no_stale", 32'(bus.pop_valid), 0);
        cyc();

        // Pop counter on requester 0 (saturating when enabled)
        bus.pop_ready = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                bus.push_valid  = 1'b1;
                bus.push_select = 2'd0;
                bus.push_data   = 8'h50 + 8'(k);
            end else begin
                bus.push_valid = 1'b0;
            end
            neg();
            if (k < 5) begin
                chk($sformatf("t6_ready_%0d", k), 32'(bus.push_ready), 1);
                exp_q[0].push_back(8'h50 + 8'(k));
            end
            if (k >= 2) begin
                chk($sformatf("t6_count0_%0d", k), 32'(bus.pop_count[0]), 32'(cnt_exp[k-2]));
                chk($sformatf("t6_count_other_%0d", k), 32'(bus.pop_count[3:1]), 0);
            end
            cyc();
        end
        bus.pop_ready = 4'b0000;
        neg();
        chk("t6_drained", 32'(bus.pop_valid), 0);

        for (int i = 0; i < NR; i++) begin
            chk($sformatf("final_queue%0d_empty", i), 32'(exp_q[i].size()), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/br_flow_demux_select_buffered.md
Name: br_flow_demux_select_buffered

Overview:
- Ready-valid demux. Each push transfer is steered by a select sideband to one of NumRequesters outputs.
- Every output has its own flop-based FIFO of Depth entries. A stalled requester therefore does not block traffic headed to other requesters, except when the pending push targets that stalled requester.
- Pop outputs are fully registered, so there is no combinational path from push_valid/push_data to the pop side.
- Sits between a single producer and multiple independent consumers, such as response routing to agents.

Parameters:
- NumRequesters, 2, number of outputs; must be >= 2.
- BitWidth, 1, payload width; must be >= 1.
- Depth, 2, entries per output FIFO; must be >= 1.
- CountWidth, 16, width of the per-requester transfer counters (optional feature only); must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- push_select  input  $clog2(NumRequesters)  destination index; part of the payload.
- push_ready  output  1  producer may transfer.
- push_valid  input  1  producer offers a transfer.
- push_data  input  BitWidth  payload.
- pop_ready  input  NumRequesters  per-requester ready.
- pop_valid  output  NumRequesters  per-requester valid.
- pop_data  output  NumRequesters x BitWidth  per-requester payload.
- pop_count  output  NumRequesters x CountWidth  per-requester transfer count (optional feature).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All FIFOs are emptied; read/write pointers and occupancy go to 0.
  - pop_valid=0 and pop_count=0.
  - pop_data is don't-care but must be deterministic; it is reset to 0.
  - A reset mid-operation discards all buffered entries. No transfer is accepted in the reset cycle; push_ready=0 while rst=1.
- push_ready = !full[push_select].
  - This is a combinational function of push_select and registered occupancy only. It does not depend on push_valid or on any pop_ready.
- Push transfer (push_valid & push_ready): push_data is written into FIFO[push_select].
- Latency: an entry is visible on pop_valid/pop_data of its requester no earlier than the cycle after the push. There is no bypass.
- Pop transfer (pop_valid[i] & pop_ready[i]): the head of FIFO[i] is removed. Multiple requesters may pop in the same cycle.
- pop_valid[i] = (occupancy[i] != 0). pop_data[i] = head entry of FIFO[i].
- Ordering: FIFO order per requester. There is no ordering guarantee across requesters.
- Simultaneous push and pop on the same FIFO:
  - Occupancy is unchanged.
  - Pointers advance with wrap-around at Depth (modulo Depth; Depth need not be a power of 2).
- Full FIFO:
  - push_ready=0 when push_select targets it, even if that requester pops in the same cycle (no pass-through).
  - A full FIFO accepts again one cycle after a pop.
- Empty FIFO: pop_valid[i]=0. pop_ready[i] is ignored.
- Occupancy counter width: $clog2(Depth+1). It never exceeds Depth and never underflows.
- Integration assertions (BR_ASSERT_INTG):
  - push_select < NumRequesters whenever push_valid=1.
  - push_valid, push_data and push_select are stable while push_valid & !push_ready.
- Implementation assertions:
  - pop_valid[i], and pop_data[i] while valid, are stable until popped.
  - Occupancy <= Depth.
  - No push into a full FIFO.
- Static checks: NumRequesters >= 2, BitWidth >= 1, Depth >= 1.

Optional Feature:
- Macro: BR_FLOW_DEMUX_SELECT_BUFFERED_COUNT_EN.
- Defined:
  - pop_count[i] increments by 1 on every pop transfer of requester i.
  - It saturates at 2^CountWidth-1, with no wrap.
  - It resets to 0 on rst.
  - The counter update is registered: the value is visible the cycle after the pop.
- Undefined:
  - pop_count is tied to 0 and no counter flops are instantiated.
  - The port is still present, so the interface is identical in both builds.

Test Plan:
- Reset, then push_valid=1, push_select=1, push_data=0xA5, all pop_ready=0 (NumRequesters=4, BitWidth=8, Depth=2) -> push accepted in cycle 0; pop_valid=4'b0010 and pop_data[1]=0xA5 from cycle 1; the other pop_valid bits stay 0.
- Fill requester 2 with 0x11 and 0x22, pop_ready[2]=0 -> push_ready=0 when push_select=2. Push to select=0 with 0x33 is still accepted, so requester 0 is not blocked by requester 2.
- Requester 2 full, push_select=2, pop_ready[2]=1 in the same cycle -> push_ready=0 that cycle (no pass-through); 0x11 pops; push_ready=1 next cycle; next pop returns 0x22.
- Stream 8 pushes to select=3 with pop_ready[3]=1 continuously -> after the first, one pop per cycle; data order 0..7 preserved; pointers wrap without loss; occupancy never exceeds 1.
- Assert rst for one cycle while FIFOs 0 and 1 each hold 2 entries -> next cycle pop_valid=0, push_ready=1 for every select, and no stale data reappears.
- With BR_FLOW_DEMUX_SELECT_BUFFERED_COUNT_EN and CountWidth=2, pop requester 0 five times -> pop_count[0] reads 1, 2, 3, 3, 3; other counters stay 0. Without the macro, pop_count remains 0 throughout.
